// File: rtl/seq_slice_alu.sv
// Multi-cycle ALU that evaluates SLICE bits per clock, LSB slice first, rippling the carry
// through a flop. Define SEQ_SLICE_ALU_ZERO_FLAG_EN to add the zero output.
module seq_slice_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainvert,
  input  logic             binvert,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned N       = WIDTH / SLICE;
  localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if (WIDTH < 2 || SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("seq_slice_alu: WIDTH must be >= 2 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]      op_q;
  logic            carry_q;
  logic [CntW-1:0] cnt_q;
  logic            zero_q;

  int unsigned     base;
  logic [SLICE-1:0] sa, sb, slice_sum, slice_res;
  logic            c, c_msb_in, set_bit;

  // Operands are stored already inverted, so the slice logic only sees A' and B'.
  always_comb begin
    base      = 32'(cnt_q) * SLICE;
    sa        = a_q[base +: SLICE];
    sb        = b_q[base +: SLICE];
    c         = carry_q;
    c_msb_in  = 1'b0;
    slice_sum = '0;
    for (int i = 0; i < int'(SLICE); i++) begin
      if (i == int'(SLICE) - 1) c_msb_in = c;
      slice_sum[i] = sa[i] ^ sb[i] ^ c;
      c = (sa[i] & sb[i]) | (c & (sa[i] ^ sb[i]));
    end
    unique case (op_q)
      2'b00:   slice_res = sa & sb;
      2'b01:   slice_res = sa | sb;
      2'b10:   slice_res = slice_sum;
      2'b11:   slice_res = slice_sum;
      default: slice_res = slice_sum;
    endcase
    // Overflow-corrected less-than; only meaningful on the MSB slice.
    set_bit = slice_sum[SLICE-1] ^ c_msb_in ^ c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= ainvert ? ~a : a;
            b_q       <= binvert ? ~b : b;
            op_q      <= op;
            carry_q   <= binvert;
            cnt_q     <= '0;
            zero_q    <= 1'b1;
            busy      <= 1'b1;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          carry_q <= c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt && op_q == 2'b11) begin
            result <= {{(WIDTH-1){1'b0}}, set_bit};
            zero_q <= ~set_bit;
          end else begin
            result[base +: SLICE] <= slice_res;
            zero_q <= zero_q & (slice_res == '0);
          end
          if (cnt_q == LastCnt) begin
            carry_out <= op_q[1] ? c : 1'b0;
            overflow  <= (op_q == 2'b10) ? (c_msb_in ^ c) : 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
  assign zero = zero_q;
`else
  logic unused_zero;
  assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_seq_slice_alu.sv
// Self-checking bench for seq_slice_alu (WIDTH=8, SLICE=2): directed vectors, handshake corner
// cases and randomized operations against an arithmetic reference model.
module tb_seq_slice_alu;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned NS = W / S;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         ainvert = 1'b0, binvert = 1'b0;
  logic [1:0]   op = 2'b00;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;
`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_slice_alu #(.WIDTH(W), .SLICE(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ainvert   (ainvert),
    .binvert   (binvert),
    .op        (op),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-word two's-complement arithmetic.
  task automatic model(input logic [7:0] ma, mb, input logic mai, mbi, input logic [1:0] mop,
                       output logic [7:0] r, output logic co, output logic ov);
    logic [7:0] ea, eb, sum;
    logic [8:0] full;
    logic       sov;
    ea   = mai ? ~ma : ma;
    eb   = mbi ? ~mb : mb;
    full = {1'b0, ea} + {1'b0, eb} + {8'd0, mbi};
    sum  = full[7:0];
    sov  = (ea[7] == eb[7]) && (sum[7] != ea[7]);
    co   = mop[1] ? full[8] : 1'b0;
    ov   = (mop == 2'b10) ? sov : 1'b0;
    case (mop)
      2'b00:   r = ea & eb;
      2'b01:   r = ea | eb;
      2'b10:   r = sum;
      default: r = {7'd0, sum[7] ^ sov};
    endcase
  endtask

  task automatic run_op(input string tag, input logic [7:0] ta, tb_b, input logic tai, tbi,
                        input logic [1:0] top);
    logic [7:0] er;
    logic       eco, eov, busy_ok;
    int         cyc;
    model(ta, tb_b, tai, tbi, top, er, eco, eov);
    @(negedge clk);
    a = ta; b = tb_b; ainvert = tai; binvert = tbi; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); ainvert = 1'($urandom); binvert = 1'($urandom);
    op = 2'($urandom);
    check({tag, " busy_after_start"}, 32'(busy), 32'd1);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, cyc, NS);
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    check({tag, " result"}, 32'(result), 32'(er));
    check({tag, " carry_out"}, 32'(carry_out), 32'(eco));
    check({tag, " overflow"}, 32'(overflow), 32'(eov));
`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
    check({tag, " zero"}, 32'(zero), 32'(er == 8'd0));
`endif
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " result_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rai, rbi;
    logic [1:0] rop;
    int         dones, early_drop;

    #2 rst_n = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry_out", 32'(carry_out), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
`ifdef SEQ_SLICE_ALU_ZERO_FLAG_EN
    check("reset zero", 32'(zero), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 2'b10);
    run_op("sub_eq",  8'h05, 8'h05, 1'b0, 1'b1, 2'b10);
    run_op("slt_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 2'b11);
    run_op("slt_neg", 8'h01, 8'h80, 1'b0, 1'b1, 2'b11);
    run_op("nor",     8'hF0, 8'h0C, 1'b1, 1'b1, 2'b00);
    run_op("or",      8'hF0, 8'h0C, 1'b0, 1'b0, 2'b01);
    check("add_fixed result", 32'(result), 32'hFC);

    // start re-pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h22; ainvert = 1'b0; binvert = 1'b0; op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    early_drop = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 2) begin
        a = 8'hAA; b = 8'h55; op = 2'b01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) dones++;
      if (i < int'(NS) && !busy) early_drop++;
      if (i == int'(NS)) begin
        check("restart done_at_latency", 32'(done), 32'd1);
        check("restart result", 32'(result), 32'h32);
      end
    end
    start = 1'b0;
    check("restart done_count", dones, 1);
    check("restart busy_early_drop", early_drop, 0);
    check("restart idle_after", 32'(busy), 32'd0);

    // Asynchronous reset in RUN cycle 2 aborts immediately.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; op = 2'b01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort carry_out", 32'(carry_out), 32'd0);
    check("abort overflow", 32'(overflow), 32'd0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no_done", dones, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no_done_after_release", dones, 0);
    run_op("post_reset_add", 8'h03, 8'h04, 1'b0, 1'b0, 2'b10);

    for (int n = 0; n < 40; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rai = 1'($urandom);
      rbi = 1'($urandom);
      rop = 2'($urandom);
      if (n % 8 == 0) rb = ra;
      run_op($sformatf("rand%0d", n), ra, rb, rai, rbi, rop);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
